// File: rtl/mux_pkg.sv
// Shared definitions for the round-robin mux: mode encodings and the channel index width helper.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int idx_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin search: first requesting channel above ptr, wrapping modulo N. Purely combinational.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] grant,
  output logic          grant_valid
);

  logic [SW-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int i = N; i >= 1; i--) begin
      idx = SW'((int'(ptr) + i) % N);
      if (req[idx]) begin
        grant       = idx;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_mux_nto1.sv
// N-to-1 mux, fixed-select or round-robin, into a single output register slot (1-cycle latency, 1 beat/cycle).
// in_ready follows the slot's take condition; MUX_LOCK_EN holds the grant on one channel until in_last.
module rr_mux_nto1
  import mux_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = 4,
  localparam int SW = idx_width(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  input  logic [N-1:0]   in_last,
  output logic [N-1:0]   in_ready,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  output logic           out_last,
  output logic [SW-1:0]  out_chan,
  input  logic           out_ready
);

  localparam logic [SW:0] N_LIM = (SW+1)'(N);

  logic          take;
  logic          grant_ok;
  logic          xfer;
  logic [SW-1:0] g;
  logic [SW-1:0] ptr;
  logic [SW-1:0] arb_grant;
  logic          arb_valid;
  logic [W-1:0]  g_data;
  logic          g_last;

`ifdef MUX_LOCK_EN
  logic          lock;
  logic [SW-1:0] lock_chan;
`endif

  assign take = !out_valid || out_ready;

  rr_arbiter #(
    .N  (N),
    .SW (SW)
  ) u_arb (
    .req         (in_valid),
    .ptr         (ptr),
    .grant       (arb_grant),
    .grant_valid (arb_valid)
  );

  always_comb begin
    g        = arb_grant;
    grant_ok = arb_valid;
    if (mode == MODE_FIXED) begin
      g        = sel;
      grant_ok = ({1'b0, sel} < N_LIM);
    end
`ifdef MUX_LOCK_EN
    // An open packet owns the output regardless of mode, sel or other requesters.
    if (lock) begin
      g        = lock_chan;
      grant_ok = 1'b1;
    end
`endif
  end

  always_comb begin
    in_ready = '0;
    if (rst_n && take && grant_ok) begin
      in_ready[g] = 1'b1;
    end
  end

  // Loop-based select keeps an out-of-range index from ever reaching the part-select.
  always_comb begin
    g_data = '0;
    g_last = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (g == SW'(k)) begin
        g_data = in_data[k*W +: W];
        g_last = in_last[k];
      end
    end
  end

  assign xfer = |(in_valid & in_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_chan  <= '0;
      ptr       <= SW'(N - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= g_data;
      out_last  <= g_last;
      out_chan  <= g;
      ptr       <= g;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MUX_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock      <= 1'b0;
      lock_chan <= '0;
    end else if (xfer) begin
      lock      <= !g_last;
      lock_chan <= g;
    end
  end
`endif

endmodule
